// File: rtl/sprite_compositor.sv
// Composites NUM_SPRITES box-locked, camera-relative sprites over the map pixel stream.
// Optional debug outline of each sprite box when SPRITE_BORDER_EN is defined.
module sprite_compositor #(
   parameter int unsigned NUM_SPRITES = 2,
   parameter int unsigned SPR_SIZE    = 128,
   parameter int unsigned LOC_W       = 12,
   parameter int unsigned SCREEN_W    = 1024,
   parameter int unsigned SCREEN_H    = 768,
   parameter int unsigned ROM_LAT     = 1,
   parameter logic [11:0] TRANS_KEY   = 12'h000,
   localparam int unsigned AW  = $clog2(SPR_SIZE),
   localparam int unsigned IDW = $clog2(NUM_SPRITES) + 1
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic [10:0]                   i_pixel_row,
   input  logic [10:0]                   i_pixel_column,
   input  logic [LOC_W-1:0]              i_cam_x,
   input  logic [LOC_W-1:0]              i_cam_y,
   input  logic [NUM_SPRITES*LOC_W-1:0]  i_spr_x,
   input  logic [NUM_SPRITES*LOC_W-1:0]  i_spr_y,
   input  logic [NUM_SPRITES*3-1:0]      i_spr_orient,
   input  logic [NUM_SPRITES-1:0]        i_spr_en,
   output logic [NUM_SPRITES*2*AW-1:0]   o_rom_addr,
   input  logic [NUM_SPRITES*12-1:0]     i_rom_data,
   output logic [12:0]                   o_sprite_pixel,
   output logic [IDW-1:0]                o_sprite_id
);

   localparam int unsigned CW = LOC_W + 2;

   logic [LOC_W-1:0]             r_cam_x, r_cam_y;
   logic [NUM_SPRITES*LOC_W-1:0] r_spr_x, r_spr_y;
   logic [NUM_SPRITES*3-1:0]     r_orient;
   logic [NUM_SPRITES-1:0]       r_en;
   logic                         w_frame_start;

   logic signed [CW-1:0] w_left [NUM_SPRITES];
   logic signed [CW-1:0] w_top  [NUM_SPRITES];
   logic signed [CW-1:0] w_lc   [NUM_SPRITES];
   logic signed [CW-1:0] w_lr   [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] w_in_box;

   logic [AW-1:0]          r_lc1     [NUM_SPRITES];
   logic [AW-1:0]          r_lr1     [NUM_SPRITES];
   logic [2:0]             r_orient1 [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] r_hit1;

   logic [2*AW-1:0]        w_addr [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] w_ok;
   logic [2*AW-1:0]        r_addr [NUM_SPRITES];
   // Index 0 is the rom_addr stage; index ROM_LAT lines up with i_rom_data.
   logic [NUM_SPRITES-1:0] r_hit_p [ROM_LAT+1];

   logic [12:0]    w_pix, r_pix;
   logic [IDW-1:0] w_id, r_id;

`ifdef SPRITE_BORDER_EN
   logic [NUM_SPRITES-1:0] w_edge;
   logic [NUM_SPRITES-1:0] r_bord_p [ROM_LAT+1];
`endif

   assign w_frame_start = (i_pixel_row == 11'd0) && (i_pixel_column == 11'd0);

   // Shadows only move at frame start so a sprite never tears mid-frame.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cam_x  <= '0;
         r_cam_y  <= '0;
         r_spr_x  <= '0;
         r_spr_y  <= '0;
         r_orient <= '0;
         r_en     <= '0;
      end else if (w_frame_start) begin
         r_cam_x  <= i_cam_x;
         r_cam_y  <= i_cam_y;
         r_spr_x  <= i_spr_x;
         r_spr_y  <= i_spr_y;
         r_orient <= i_spr_orient;
         r_en     <= i_spr_en;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
         w_left[i] = $signed({2'b00, r_spr_x[i*LOC_W +: LOC_W]}) - $signed({2'b00, r_cam_x})
                   + $signed(CW'(SCREEN_W/2 - SPR_SIZE/2));
         w_top[i]  = $signed({2'b00, r_spr_y[i*LOC_W +: LOC_W]}) - $signed({2'b00, r_cam_y})
                   + $signed(CW'(SCREEN_H/2 - SPR_SIZE/2));
         w_lc[i]   = $signed({{(CW-11){1'b0}}, i_pixel_column}) - w_left[i];
         w_lr[i]   = $signed({{(CW-11){1'b0}}, i_pixel_row}) - w_top[i];
         // Zero upper bits means 0 <= offset < SPR_SIZE; negatives have the sign bit set.
         w_in_box[i] = r_en[i] && (w_lc[i][CW-1:AW] == '0) && (w_lr[i][CW-1:AW] == '0);
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_hit1 <= '0;
         for (int i = 0; i < NUM_SPRITES; i++) begin
            r_lc1[i]     <= '0;
            r_lr1[i]     <= '0;
            r_orient1[i] <= '0;
         end
      end else begin
         r_hit1 <= w_in_box;
         for (int i = 0; i < NUM_SPRITES; i++) begin
            r_lc1[i]     <= w_lc[i][AW-1:0];
            r_lr1[i]     <= w_lr[i][AW-1:0];
            r_orient1[i] <= r_orient[i*3 +: 3];
         end
      end
   end

   // S-1-x is the bitwise complement of an AW-bit offset.
   always_comb begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
         w_ok[i]   = 1'b1;
         w_addr[i] = '0;
         case (r_orient1[i])
            3'b100:  w_addr[i] = {r_lr1[i], r_lc1[i]};
            3'b110:  w_addr[i] = {r_lc1[i], ~r_lr1[i]};
            3'b000:  w_addr[i] = {~r_lr1[i], ~r_lc1[i]};
            3'b010:  w_addr[i] = {~r_lc1[i], r_lr1[i]};
            default: w_ok[i]   = 1'b0;
         endcase
      end
   end

`ifdef SPRITE_BORDER_EN
   always_comb begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
         w_edge[i] = (r_lc1[i] == '0) || (r_lc1[i] == '1) || (r_lr1[i] == '0) || (r_lr1[i] == '1);
      end
   end
`endif

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < NUM_SPRITES; i++) r_addr[i] <= '0;
         for (int k = 0; k <= ROM_LAT; k++) r_hit_p[k] <= '0;
`ifdef SPRITE_BORDER_EN
         for (int k = 0; k <= ROM_LAT; k++) r_bord_p[k] <= '0;
`endif
      end else begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            if (r_hit1[i] && w_ok[i]) r_addr[i] <= w_addr[i];
         end
         r_hit_p[0] <= r_hit1 & w_ok;
         for (int k = 1; k <= ROM_LAT; k++) r_hit_p[k] <= r_hit_p[k-1];
`ifdef SPRITE_BORDER_EN
         r_bord_p[0] <= r_hit1 & w_ok & w_edge;
         for (int k = 1; k <= ROM_LAT; k++) r_bord_p[k] <= r_bord_p[k-1];
`endif
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_SPRITES; i++) o_rom_addr[i*2*AW +: 2*AW] = r_addr[i];
   end

   // Walk from lowest priority upward so the lowest opaque index overwrites the rest.
   always_comb begin
      w_pix = '0;
      w_id  = '1;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (r_hit_p[ROM_LAT][i] && (i_rom_data[i*12 +: 12] != TRANS_KEY)) begin
            w_pix = {1'b1, i_rom_data[i*12 +: 12]};
            w_id  = IDW'(i);
         end
`ifdef SPRITE_BORDER_EN
         if (r_bord_p[ROM_LAT][i]) begin
            w_pix = 13'h1FFF;
            w_id  = IDW'(i);
         end
`endif
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_pix <= '0;
         r_id  <= '1;
      end else begin
         r_pix <= w_pix;
         r_id  <= w_id;
      end
   end

   assign o_sprite_pixel = r_pix;
   assign o_sprite_id    = r_id;

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor with a behavioural 1-cycle sprite ROM.
// Honours SPRITE_BORDER_EN in its reference model.
module tb_sprite_compositor;

   localparam int NS = 2;
   localparam int S  = 128;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] pix_row, pix_col;
   logic [11:0] cam_x, cam_y;
   logic [23:0] spr_x, spr_y;
   logic [5:0]  spr_orient;
   logic [1:0]  spr_en;
   logic [27:0] rom_addr;
   logic [23:0] rom_data;
   logic [12:0] sprite_pixel;
   logic [1:0]  sprite_id;

   logic [11:0] rom_q     [NS];
   logic        rom_mode  [NS];
   logic [11:0] rom_solid [NS];

   int m_cx, m_cy;
   int m_sx [NS];
   int m_sy [NS];
   logic [2:0]  m_or   [NS];
   logic        m_en   [NS];
   logic [13:0] m_addr [NS];

   logic [14:0] q_pix  [$];
   logic [27:0] q_addr [$];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sprite_compositor dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_pixel_row    (pix_row),
      .i_pixel_column (pix_col),
      .i_cam_x        (cam_x),
      .i_cam_y        (cam_y),
      .i_spr_x        (spr_x),
      .i_spr_y        (spr_y),
      .i_spr_orient   (spr_orient),
      .i_spr_en       (spr_en),
      .o_rom_addr     (rom_addr),
      .i_rom_data     (rom_data),
      .o_sprite_pixel (sprite_pixel),
      .o_sprite_id    (sprite_id)
   );

   function automatic logic [11:0] rom_fn(input int s, input logic [13:0] a);
      if (rom_mode[s]) return rom_solid[s];
      return {1'b1, s[0], a[9:0]};
   endfunction

   always_ff @(posedge clk) begin
      for (int i = 0; i < NS; i++) rom_q[i] <= rom_fn(i, rom_addr[i*14 +: 14]);
   end
   assign rom_data = {rom_q[1], rom_q[0]};

   function automatic logic [12:0] ed(input logic [12:0] v);
`ifdef SPRITE_BORDER_EN
      return (v == 13'h0) ? v : 13'h1FFF;
`else
      return v;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_push(input int row, input int col);
      logic [12:0] pix;
      logic [1:0]  id;
      logic [13:0] a;
      logic [11:0] d;
      int left, top, lc, lr;
      bit ok, hit;
      pix = '0;
      id  = 2'b11;
      for (int i = NS - 1; i >= 0; i--) begin
         left = m_sx[i] - m_cx + 512 - 64;
         top  = m_sy[i] - m_cy + 384 - 64;
         lc   = col - left;
         lr   = row - top;
         ok   = 1'b1;
         a    = '0;
         case (m_or[i])
            3'b100:  a = 14'(lr * S + lc);
            3'b110:  a = 14'(lc * S + (S - 1 - lr));
            3'b000:  a = 14'((S - 1 - lr) * S + (S - 1 - lc));
            3'b010:  a = 14'((S - 1 - lc) * S + lr);
            default: ok = 1'b0;
         endcase
         hit = m_en[i] && ok && lc >= 0 && lc < S && lr >= 0 && lr < S;
         if (hit) begin
            m_addr[i] = a;
            d = rom_fn(i, a);
            if (d != 12'h000) begin
               pix = {1'b1, d};
               id  = 2'(i);
            end
`ifdef SPRITE_BORDER_EN
            if (lc == 0 || lc == S - 1 || lr == 0 || lr == S - 1) begin
               pix = 13'h1FFF;
               id  = 2'(i);
            end
`endif
         end
      end
      q_pix.push_back({pix, id});
      q_addr.push_back({m_addr[1], m_addr[0]});
      if (row == 0 && col == 0) begin
         m_cx = int'(cam_x);
         m_cy = int'(cam_y);
         for (int i = 0; i < NS; i++) begin
            m_sx[i] = int'(spr_x[i*12 +: 12]);
            m_sy[i] = int'(spr_y[i*12 +: 12]);
            m_or[i] = spr_orient[i*3 +: 3];
            m_en[i] = spr_en[i];
         end
      end
   endtask

   task automatic step(input int row, input int col);
      pix_row = 11'(row);
      pix_col = 11'(col);
      model_push(row, col);
      @(posedge clk);
      #1;
      if (q_addr.size() > 1) check("rom_addr", 32'(rom_addr), 32'(q_addr.pop_front()));
      if (q_pix.size() > 3) check("pixel_id", 32'({sprite_pixel, sprite_id}), 32'(q_pix.pop_front()));
   endtask

   task automatic scan(input int row, input int c0, input int c1);
      for (int c = c0; c <= c1; c++) step(row, c);
   endtask

   task automatic flush();
      repeat (4) step(700, 1000);
   endtask

   // Holds one pixel long enough to sample its address and its final pixel directly.
   task automatic probe(input int row, input int col, input int sp, input logic [13:0] exp_addr,
                        input logic [12:0] exp_pix, input logic [1:0] exp_id);
      step(row, col);
      step(row, col);
      check("probe_addr", 32'(rom_addr[sp*14 +: 14]), 32'(exp_addr));
      step(row, col);
      step(row, col);
      check("probe_pix", 32'(sprite_pixel), 32'(exp_pix));
      check("probe_id", 32'(sprite_id), 32'(exp_id));
   endtask

   task automatic set_spr(input int i, input int x, input int y, input logic [2:0] o,
                          input logic en);
      spr_x[i*12 +: 12]    = 12'(x);
      spr_y[i*12 +: 12]    = 12'(y);
      spr_orient[i*3 +: 3] = o;
      spr_en[i]            = en;
   endtask

   task automatic model_clear();
      q_pix.delete();
      q_addr.delete();
      m_cx = 0;
      m_cy = 0;
      for (int i = 0; i < NS; i++) begin
         m_sx[i] = 0; m_sy[i] = 0; m_or[i] = 3'b000; m_en[i] = 1'b0; m_addr[i] = '0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      pix_row = 11'd700; pix_col = 11'd1000;
      cam_x = '0; cam_y = '0; spr_x = '0; spr_y = '0; spr_orient = '0; spr_en = '0;
      rom_mode[0] = 1'b0; rom_mode[1] = 1'b0;
      rom_solid[0] = 12'h000; rom_solid[1] = 12'h000;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      check("reset_pix", 32'(sprite_pixel), 32'h0);
      check("reset_id", 32'(sprite_id), 32'h3);
      check("reset_addr", 32'(rom_addr), 32'h0);
      rst = 1'b0;

      // Alignment: sprite 0 centred on the camera.
      cam_x = 12'd2048; cam_y = 12'd1536;
      set_spr(0, 2048, 1536, 3'b100, 1'b1);
      set_spr(1, 0, 0, 3'b100, 1'b0);
      step(0, 0);
      scan(320, 440, 584);
      scan(321, 440, 584);
      scan(447, 440, 584);
      scan(448, 440, 460);
      probe(320, 448, 0, 14'd0, ed(13'h1800), 2'd0);
      probe(320, 575, 0, 14'd127, ed(13'h187F), 2'd0);
      probe(320, 576, 0, 14'd127, 13'h0, 2'd3);

      // Box lock: camera moves right, box moves left, art stays anchored.
      for (int f = 1; f <= 3; f++) begin
         flush();
         cam_x = 12'(2048 + 16 * f);
         step(0, 0);
         probe(320, 448 - 16 * f, 0, 14'd0, ed(13'h1800), 2'd0);
         probe(320, 447 - 16 * f, 0, 14'd0, 13'h0, 2'd3);
         scan(330, 380, 600);
      end
      flush();
      cam_x = 12'd2048;

      // Rotation.
      set_spr(0, 2048, 1536, 3'b110, 1'b1);
      step(0, 0);
      probe(320, 453, 0, 14'd767, ed(13'h1AFF), 2'd0);
      scan(340, 440, 584);
      flush();
      set_spr(0, 2048, 1536, 3'b000, 1'b1);
      step(0, 0);
      scan(340, 440, 584);
      flush();
      set_spr(0, 2048, 1536, 3'b010, 1'b1);
      step(0, 0);
      scan(340, 440, 584);
      flush();
      set_spr(0, 2048, 1536, 3'b011, 1'b1);
      step(0, 0);
      probe(320, 453, 0, 14'd20, 13'h0, 2'd3);
      scan(340, 440, 584);

      // Priority and transparency with coincident sprites.
      flush();
      set_spr(0, 2048, 1536, 3'b100, 1'b1);
      set_spr(1, 2048, 1536, 3'b100, 1'b1);
      rom_mode[0] = 1'b1; rom_mode[1] = 1'b1;
      rom_solid[0] = 12'h0F0; rom_solid[1] = 12'hF00;
      step(0, 0);
      probe(330, 460, 0, 14'd1292, 13'h10F0, 2'd0);
      scan(330, 440, 584);
      flush();
      rom_solid[0] = 12'h000;
      probe(330, 460, 0, 14'd1292, 13'h1F00, 2'd1);
      scan(330, 440, 584);

      // Clipping at the left screen edge and frame-latched positions.
      flush();
      rom_mode[0] = 1'b0; rom_mode[1] = 1'b0;
      set_spr(0, 2048, 1536, 3'b100, 1'b0);
      set_spr(1, 1560, 1536, 3'b100, 1'b1);
      step(0, 0);
      scan(330, 990, 1023);
      scan(330, 0, 100);
      probe(330, 0, 1, 14'd1320, 13'h1D28, 2'd1);
      probe(330, 87, 1, 14'd1407, ed(13'h1D7F), 2'd1);
      probe(330, 88, 1, 14'd1407, 13'h0, 2'd3);
      probe(330, 1023, 1, 14'd1407, 13'h0, 2'd3);
      set_spr(1, 1660, 1536, 3'b100, 1'b1);
      probe(330, 0, 1, 14'd1320, 13'h1D28, 2'd1);
      step(0, 0);
      probe(330, 0, 1, 14'd1320, 13'h0, 2'd3);
      probe(330, 60, 1, 14'd1280, ed(13'h1D00), 2'd1);

      // Reset mid-line with a sprite pixel on the output.
      flush();
      set_spr(0, 2048, 1536, 3'b100, 1'b1);
      set_spr(1, 0, 0, 3'b100, 1'b0);
      step(0, 0);
      repeat (4) step(330, 460);
      #1 rst = 1'b1;
      #1;
      check("midreset_pix", 32'(sprite_pixel), 32'h0);
      check("midreset_id", 32'(sprite_id), 32'h3);
      check("midreset_addr", 32'(rom_addr), 32'h0);
      model_clear();
      #1 rst = 1'b0;
      probe(330, 460, 0, 14'd0, 13'h0, 2'd3);
      scan(330, 440, 584);
      step(0, 0);
      scan(330, 440, 584);
      flush();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
